// File: rtl/audiox_pkg.sv
// audiox_pkg: shared FSM state, port-select and register-index definitions
package audiox_pkg;

    typedef enum logic {ST_IDLE, ST_LOCK_B} arb_state_e;
    typedef enum logic {PORT_A, PORT_B} port_e;

    localparam int unsigned ZERO = 0;
    localparam int unsigned SP   = 1;
    localparam int unsigned RA   = 2;
    localparam int unsigned T0   = 3;
    localparam int unsigned T1   = 4;
    localparam int unsigned T2   = 5;
    localparam int unsigned T3   = 6;
    localparam int unsigned S0   = 7;
    localparam int unsigned S1   = 8;
    localparam int unsigned S2   = 9;
    localparam int unsigned S3   = 10;
    localparam int unsigned P0   = 11;
    localparam int unsigned P1   = 12;
    localparam int unsigned P2   = 13;
    localparam int unsigned P3   = 14;
    localparam int unsigned P4   = 15;

endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: two valid/ready write-request ports (A core writeback, B sample loader)
interface rf_write_arbiter_if #(
    parameter int DATA_W = 24,
    parameter int IDX_W  = 4
);
    logic              a_valid;
    logic              a_ready;
    logic [IDX_W-1:0]  a_index;
    logic [DATA_W-1:0] a_data;
    logic              b_valid;
    logic              b_ready;
    logic [IDX_W-1:0]  b_index;
    logic [DATA_W-1:0] b_data;
    logic              b_lock;

    modport master (
        output a_valid, a_index, a_data, b_valid, b_index, b_data, b_lock,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_index, a_data, b_valid, b_index, b_data, b_lock,
        output a_ready, b_ready
    );
endinterface

// File: rtl/rf_wr_rr_sel.sv
// rf_wr_rr_sel: round-robin tie-break plus port-B burst lock; produces the two readies
module rf_wr_rr_sel
    import audiox_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic a_valid,
    input  logic b_valid,
    input  logic b_lock,
    output logic a_ready,
    output logic b_ready
);
    arb_state_e state_q, state_d;
    port_e      last_q, last_d;
    logic [3:0] burst_q, burst_d;
    logic       idle;

    // Grant: readies never depend on the other side's ready, and are held low during reset
    always_comb begin
        idle    = state_q == ST_IDLE;
        a_ready = rst_n && a_valid && idle && (!b_valid || last_q == PORT_B);
        b_ready = rst_n && b_valid && (!idle || !a_valid || last_q == PORT_A);
    end

    // Next state: lock entry on a locked B beat, lock exit leaves last_grant at B so A wins next tie
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        burst_d = burst_q;
        if (idle) begin
            if (a_ready) last_d = PORT_A;
            if (b_ready) begin
                last_d = PORT_B;
                if (b_lock && BURST_MAX > 1) begin
                    state_d = ST_LOCK_B;
                    burst_d = 4'd1;
                end
            end
        end else if (!b_valid || !b_lock || burst_q + 4'd1 == 4'(BURST_MAX)) begin
            state_d = ST_IDLE;
            last_d  = PORT_B;
            burst_d = '0;
        end else begin
            burst_d = burst_q + 4'd1;
        end
    end

    // Arbitration state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            last_q  <= PORT_B;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            burst_q <= burst_d;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: merges two write requesters onto one registered register-file write port
module rf_write_arbiter
    import audiox_pkg::*;
#(
    parameter int DATA_W    = 24,
    parameter int IDX_W     = 4,
    parameter int BURST_MAX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    rf_write_arbiter_if.slave   req,
    output logic                rf_write_enable,
    output logic [IDX_W-1:0]    rf_write_index,
    output logic [DATA_W-1:0]   rf_write_data,
    output logic [7:0]          zero_drop_cnt
);
    logic              acc;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [7:0]        zcnt_q, zcnt_d;

    rf_wr_rr_sel #(.BURST_MAX(BURST_MAX)) u_sel (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (req.a_valid),
        .b_valid (req.b_valid),
        .b_lock  (req.b_lock),
        .a_ready (req.a_ready),
        .b_ready (req.b_ready)
    );

    // Select the accepted beat; index-0 beats are dropped and counted instead of written
    always_comb begin
        acc       = req.a_ready || req.b_ready;
        idx       = req.a_ready ? req.a_index : req.b_index;
        data      = req.a_ready ? req.a_data : req.b_data;
        wr_en_d   = acc && idx != IDX_W'(ZERO);
        wr_idx_d  = acc ? idx : wr_idx_q;
        wr_data_d = acc ? data : wr_data_q;
        zcnt_d    = (acc && idx == IDX_W'(ZERO) && zcnt_q != 8'hFF) ? zcnt_q + 8'd1 : zcnt_q;
    end

    // Write-port and drop-counter registers; reset also cancels any in-flight write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            wr_data_q <= '0;
            zcnt_q    <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            wr_data_q <= wr_data_d;
            zcnt_q    <= zcnt_d;
        end
    end

    assign rf_write_enable = wr_en_q;
    assign rf_write_index  = wr_idx_q;
    assign rf_write_data   = wr_data_q;
    assign zero_drop_cnt   = zcnt_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed scenarios with hand-computed grants and writes
module tb_rf_write_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en, wr1_en;
    logic [3:0]  wr_idx, wr1_idx;
    logic [23:0] wr_data, wr1_data;
    logic [7:0]  zcnt, zcnt1;
    int          n_cmp = 0;
    int          n_bad = 0;

    rf_write_arbiter_if #(.DATA_W(24), .IDX_W(4)) ifc ();
    rf_write_arbiter_if #(.DATA_W(24), .IDX_W(4)) ifc1 ();

    rf_write_arbiter #(.DATA_W(24), .IDX_W(4), .BURST_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(ifc),
        .rf_write_enable(wr_en), .rf_write_index(wr_idx),
        .rf_write_data(wr_data), .zero_drop_cnt(zcnt)
    );

    rf_write_arbiter #(.DATA_W(24), .IDX_W(4), .BURST_MAX(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(ifc1),
        .rf_write_enable(wr1_en), .rf_write_index(wr1_idx),
        .rf_write_data(wr1_data), .zero_drop_cnt(zcnt1)
    );

    always #5 clk = ~clk;

    task automatic drive_idle;
        ifc.a_valid = 0; ifc.a_index = 0; ifc.a_data = 0;
        ifc.b_valid = 0; ifc.b_index = 0; ifc.b_data = 0; ifc.b_lock = 0;
        ifc1.a_valid = 0; ifc1.a_index = 0; ifc1.a_data = 0;
        ifc1.b_valid = 0; ifc1.b_index = 0; ifc1.b_data = 0; ifc1.b_lock = 0;
    endtask

    task automatic test_reset;
        drive_idle();
        rst_n = 0;
        ifc.a_valid = 1; ifc.a_index = 4'd3;
        ifc.b_valid = 1; ifc.b_index = 4'd2;
        repeat (2) @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_en: got %b want 0", wr_en); end
        n_cmp++; if (wr_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx: got %0d want 0", wr_idx); end
        n_cmp++; if (wr_data !== 24'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", wr_data); end
        n_cmp++; if (zcnt !== 8'd0) begin n_bad++; $display("FAIL reset_zcnt: got %0d want 0", zcnt); end
        n_cmp++; if ({ifc.a_ready, ifc.b_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {ifc.a_ready, ifc.b_ready}); end
        drive_idle();
        rst_n = 1;
    endtask

    task automatic test_alternate;
        logic [1:0] g [3] = '{2'd1, 2'd2, 2'd1};
        logic e_en = 0; logic [3:0] e_idx = 0; logic [23:0] e_data = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (wr_en !== e_en || (e_en && {wr_idx, wr_data} !== {e_idx, e_data})) begin
                n_bad++; $display("FAIL alt_write c%0d: got en=%b idx=%0d data=%h want en=%b idx=%0d data=%h", c, wr_en, wr_idx, wr_data, e_en, e_idx, e_data);
            end
            if (c == 3) break;
            ifc.a_valid = 1; ifc.a_index = 4'd5; ifc.a_data = 24'h0A0A0A;
            ifc.b_valid = 1; ifc.b_index = 4'd6; ifc.b_data = 24'h0B0B0B; ifc.b_lock = 0;
            #1;
            n_cmp++;
            if ({ifc.a_ready, ifc.b_ready} !== {g[c] == 2'd1, g[c] == 2'd2}) begin
                n_bad++; $display("FAIL alt_grant c%0d: got ab=%b%b want grant %0d", c, ifc.a_ready, ifc.b_ready, g[c]);
            end
            e_en = 1; e_idx = g[c] == 2'd1 ? 4'd5 : 4'd6; e_data = g[c] == 2'd1 ? 24'h0A0A0A : 24'h0B0B0B;
        end
        drive_idle();
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL alt_quiet: got %b want 0", wr_en); end
    endtask

    task automatic test_a_only;
        @(negedge clk);
        ifc.a_valid = 1; ifc.a_index = 4'd4; ifc.a_data = 24'h123456;
        #1;
        n_cmp++; if ({ifc.a_ready, ifc.b_ready} !== 2'b10) begin n_bad++; $display("FAIL a_only_ready: got %b want 10", {ifc.a_ready, ifc.b_ready}); end
        @(negedge clk);
        drive_idle();
        n_cmp++;
        if ({wr_en, wr_idx, wr_data} !== {1'b1, 4'd4, 24'h123456}) begin
            n_bad++; $display("FAIL a_only_write: got en=%b idx=%0d data=%h want en=1 idx=4 data=123456", wr_en, wr_idx, wr_data);
        end
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL a_only_single: got %b want 0", wr_en); end
    endtask

    task automatic test_burst;
        logic [1:0] g [9] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd0, 2'd1};
        int nb = 0;
        logic e_en = 0; logic [3:0] e_idx = 0; logic [23:0] e_data = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++;
            if (wr_en !== e_en || (e_en && {wr_idx, wr_data} !== {e_idx, e_data})) begin
                n_bad++; $display("FAIL burst_write c%0d: got en=%b idx=%0d data=%h want en=%b idx=%0d data=%h", c, wr_en, wr_idx, wr_data, e_en, e_idx, e_data);
            end
            if (c == 9) break;
            ifc.a_valid = 1; ifc.a_index = 4'd8; ifc.a_data = 24'hAAAAAA;
            ifc.b_valid = nb < 6; ifc.b_index = 4'd7; ifc.b_data = 24'hB00000 + 24'(nb); ifc.b_lock = 1;
            #1;
            n_cmp++;
            if ({ifc.a_ready, ifc.b_ready} !== {g[c] == 2'd1, g[c] == 2'd2}) begin
                n_bad++; $display("FAIL burst_grant c%0d: got ab=%b%b want grant %0d", c, ifc.a_ready, ifc.b_ready, g[c]);
            end
            e_en = g[c] != 2'd0;
            e_idx = g[c] == 2'd1 ? 4'd8 : 4'd7;
            e_data = g[c] == 2'd1 ? 24'hAAAAAA : 24'hB00000 + 24'(nb);
            if (g[c] == 2'd2) nb++;
        end
        drive_idle();
    endtask

    task automatic test_lock_abandon;
        logic [4:0] av = 5'b01110, bv = 5'b11011, bl = 5'b01111;
        logic [1:0] g [5] = '{2'd2, 2'd2, 2'd0, 2'd1, 2'd2};
        int nb = 0;
        logic e_en = 0; logic [3:0] e_idx = 0; logic [23:0] e_data = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_cmp++;
            if (wr_en !== e_en || (e_en && {wr_idx, wr_data} !== {e_idx, e_data})) begin
                n_bad++; $display("FAIL abandon_write c%0d: got en=%b idx=%0d data=%h want en=%b idx=%0d data=%h", c, wr_en, wr_idx, wr_data, e_en, e_idx, e_data);
            end
            if (c == 5) break;
            ifc.a_valid = av[c]; ifc.a_index = 4'd9; ifc.a_data = 24'h111111;
            ifc.b_valid = bv[c]; ifc.b_index = 4'd10; ifc.b_data = 24'h220000 + 24'(nb); ifc.b_lock = bl[c];
            #1;
            n_cmp++;
            if ({ifc.a_ready, ifc.b_ready} !== {g[c] == 2'd1, g[c] == 2'd2}) begin
                n_bad++; $display("FAIL abandon_grant c%0d: got ab=%b%b want grant %0d", c, ifc.a_ready, ifc.b_ready, g[c]);
            end
            e_en = g[c] != 2'd0;
            e_idx = g[c] == 2'd1 ? 4'd9 : 4'd10;
            e_data = g[c] == 2'd1 ? 24'h111111 : 24'h220000 + 24'(nb);
            if (g[c] == 2'd2) nb++;
        end
        drive_idle();
    endtask

    task automatic test_zero_drop;
        @(negedge clk);
        n_cmp++; if (zcnt !== 8'd0) begin n_bad++; $display("FAIL zero_start: got %0d want 0", zcnt); end
        ifc.a_valid = 1; ifc.a_index = 4'd0; ifc.a_data = 24'h5A5A5A;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL zero_no_write beat%0d: got %b want 0", i, wr_en); end
            n_cmp++; if (zcnt !== 8'(i > 255 ? 255 : i)) begin n_bad++; $display("FAIL zero_cnt beat%0d: got %0d want %0d", i, zcnt, i > 255 ? 255 : i); end
        end
        drive_idle();
        @(negedge clk);
        n_cmp++; if (zcnt !== 8'd255) begin n_bad++; $display("FAIL zero_hold: got %0d want 255", zcnt); end
    endtask

    task automatic test_reset_mid_burst;
        @(negedge clk);
        ifc.b_valid = 1; ifc.b_index = 4'd11; ifc.b_data = 24'h330000; ifc.b_lock = 1;
        @(negedge clk);
        n_cmp++;
        if ({wr_en, wr_idx, wr_data} !== {1'b1, 4'd11, 24'h330000}) begin
            n_bad++; $display("FAIL rst_burst_first: got en=%b idx=%0d data=%h want en=1 idx=11 data=330000", wr_en, wr_idx, wr_data);
        end
        ifc.b_data = 24'h330001;
        #1;
        n_cmp++; if (ifc.b_ready !== 1'b1) begin n_bad++; $display("FAIL rst_burst_lock_ready: got %b want 1", ifc.b_ready); end
        #1 rst_n = 0;
        #1;
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_async_clear: got %b want 0", wr_en); end
        n_cmp++; if (ifc.b_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_low: got %b want 0", ifc.b_ready); end
        n_cmp++; if (zcnt !== 8'd0) begin n_bad++; $display("FAIL rst_zcnt: got %0d want 0", zcnt); end
        repeat (2) @(negedge clk);
        drive_idle();
        rst_n = 1;
        @(negedge clk);
        n_cmp++; if (wr_en !== 1'b0) begin n_bad++; $display("FAIL rst_no_write: got %b want 0", wr_en); end
        ifc.a_valid = 1; ifc.a_index = 4'd12; ifc.a_data = 24'hC0C0C0;
        ifc.b_valid = 1; ifc.b_index = 4'd13; ifc.b_data = 24'hD0D0D0; ifc.b_lock = 0;
        #1;
        n_cmp++; if ({ifc.a_ready, ifc.b_ready} !== 2'b10) begin n_bad++; $display("FAIL rst_first_tie: got %b want 10", {ifc.a_ready, ifc.b_ready}); end
        @(negedge clk);
        drive_idle();
        n_cmp++;
        if ({wr_en, wr_idx, wr_data} !== {1'b1, 4'd12, 24'hC0C0C0}) begin
            n_bad++; $display("FAIL rst_first_write: got en=%b idx=%0d data=%h want en=1 idx=12 data=c0c0c0", wr_en, wr_idx, wr_data);
        end
    endtask

    task automatic test_burst_max1;
        logic [1:0] g [3] = '{2'd2, 2'd1, 2'd2};
        logic [2:0] av = 3'b010;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (c == 2) begin
                n_cmp++;
                if ({wr1_en, wr1_idx, wr1_data} !== {1'b1, 4'd15, 24'hA1A1A1}) begin
                    n_bad++; $display("FAIL max1_write: got en=%b idx=%0d data=%h want en=1 idx=15 data=a1a1a1", wr1_en, wr1_idx, wr1_data);
                end
            end
            ifc1.a_valid = av[c]; ifc1.a_index = 4'd15; ifc1.a_data = 24'hA1A1A1;
            ifc1.b_valid = 1; ifc1.b_index = 4'd14; ifc1.b_data = 24'hB1B1B1; ifc1.b_lock = 1;
            #1;
            n_cmp++;
            if ({ifc1.a_ready, ifc1.b_ready} !== {g[c] == 2'd1, g[c] == 2'd2}) begin
                n_bad++; $display("FAIL max1_grant c%0d: got ab=%b%b want grant %0d", c, ifc1.a_ready, ifc1.b_ready, g[c]);
            end
        end
        @(negedge clk);
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_a_only();
        test_burst();
        test_lock_abandon();
        test_zero_drop();
        test_reset_mid_burst();
        test_burst_max1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
